// File: rtl/bytes_block_loader.sv
// bytes_block_loader
//   Collects a valid/ready byte stream into one number_of_bytes*8 block register.
//   key_in/offset_in are captured with the first byte of each block. A block ends
//   when number_of_bytes bytes have been accepted, or earlier on byte_last. Lanes
//   that were never written read as zero. The finished block is held on a
//   valid/ready output until the consumer takes it.
//
// Ports
//   clk, reset_n                  rising-edge clock, async active-low reset
//   byte_in/valid/last/ready      input byte stream; byte_last ends a short block
//   key_in, offset_in             sampled on the first accepted byte of a block
//   block_data                    assembled block, byte k at [8k+7:8k]
//   block_key, block_offset       captured key and offset
//   block_len                     bytes in the block (1..number_of_bytes)
//   block_valid, block_ready      output handshake
module bytes_block_loader #(
  parameter  int number_of_bytes = 512,
  localparam int CW              = $clog2(number_of_bytes + 1)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid,
  input  logic                         byte_last,
  output logic                         byte_ready,
  input  logic [7:0]                   key_in,
  input  logic [7:0]                   offset_in,
  output logic [number_of_bytes*8-1:0] block_data,
  output logic [7:0]                   block_key,
  output logic [7:0]                   block_offset,
  output logic [CW-1:0]                block_len,
  output logic                         block_valid,
  input  logic                         block_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                         state_q,  state_d;
  logic [CW-1:0]                  count_q,  count_d;
  logic [number_of_bytes*8-1:0]   data_q,   data_d;
  logic [7:0]                     key_q,    key_d;
  logic [7:0]                     offset_q, offset_d;
  logic [CW-1:0]                  len_q,    len_d;
  logic                           ready_q,  ready_d;
  logic                           accept;

  assign accept = byte_valid & ready_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    data_d   = data_q;
    key_d    = key_q;
    offset_d = offset_q;
    len_d    = len_q;

    unique case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          // Lane decoder on count; in IDLE count is 0, so the first byte lands in lane 0.
          for (int k = 0; k < number_of_bytes; k++) begin
            if (count_q == CW'(k)) data_d[8*k +: 8] = byte_in;
          end
          if (state_q == IDLE) begin
            key_d    = key_in;
            offset_d = offset_in;
          end
          count_d = count_q + CW'(1);
          if (byte_last || count_d == CW'(number_of_bytes)) begin
            state_d = DONE;
            len_d   = count_d;
          end else begin
            state_d = FILL;
          end
        end
      end
      DONE: begin
        if (block_ready) begin
          // Clearing here is what keeps a later short block zero-padded.
          state_d = IDLE;
          count_d = '0;
          data_d  = '0;
          len_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered ready: low through reset, high from the first clock after release,
    // and dropped on the same edge that completes a block.
    ready_d = (state_d != DONE);
  end

  // NOTE: the wide block register is reset like any other flop, because padding
  // lanes must read zero after reset, not just after a consume.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      data_q   <= '0;
      key_q    <= '0;
      offset_q <= '0;
      len_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      data_q   <= data_d;
      key_q    <= key_d;
      offset_q <= offset_d;
      len_q    <= len_d;
      ready_q  <= ready_d;
    end
  end

  assign byte_ready   = ready_q;
  assign block_valid  = (state_q == DONE);
  assign block_data   = data_q;
  assign block_key    = key_q;
  assign block_offset = offset_q;
  assign block_len    = len_q;

endmodule

// File: tb/tb_bytes_block_loader.sv
// Bench for bytes_block_loader: a 4-byte instance driven by directed vectors and
// checked through a scoreboard queue, plus a 512-byte instance for the full-size block.
module tb_bytes_block_loader;

  localparam int N   = 4;
  localparam int CW  = 3;
  localparam int N2  = 512;
  localparam int CW2 = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // 4-byte instance
  logic [7:0]    byte_in, key_in, offset_in;
  logic          byte_valid, byte_last, byte_ready;
  logic [N*8-1:0] block_data;
  logic [7:0]    block_key, block_offset;
  logic [CW-1:0] block_len;
  logic          block_valid, block_ready;

  // 512-byte instance
  logic [7:0]     byte_in2, key_in2, offset_in2;
  logic           byte_valid2, byte_last2, byte_ready2;
  logic [N2*8-1:0] block_data2;
  logic [7:0]     block_key2, block_offset2;
  logic [CW2-1:0] block_len2;
  logic           block_valid2, block_ready2;

  bytes_block_loader #(.number_of_bytes(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
    .key_in(key_in), .offset_in(offset_in),
    .block_data(block_data), .block_key(block_key), .block_offset(block_offset),
    .block_len(block_len), .block_valid(block_valid), .block_ready(block_ready)
  );

  bytes_block_loader #(.number_of_bytes(N2)) dut512 (
    .clk(clk), .reset_n(reset_n),
    .byte_in(byte_in2), .byte_valid(byte_valid2), .byte_last(byte_last2), .byte_ready(byte_ready2),
    .key_in(key_in2), .offset_in(offset_in2),
    .block_data(block_data2), .block_key(block_key2), .block_offset(block_offset2),
    .block_len(block_len2), .block_valid(block_valid2), .block_ready(block_ready2)
  );

  typedef struct packed {
    logic [N*8-1:0] data;
    logic [7:0]     key;
    logic [7:0]     off;
    logic [CW-1:0]  len;
  } exp_t;

  exp_t sb_q[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a block is consumed at the next rising edge whenever valid and ready
  // are both high at the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && block_valid && block_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_block", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("blk_data",   64'(block_data),   64'(e.data));
        check("blk_key",    64'(block_key),    64'(e.key));
        check("blk_offset", 64'(block_offset), 64'(e.off));
        check("blk_len",    64'(block_len),    64'(e.len));
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic last, input logic [7:0] k, input logic [7:0] o);
    int guard;
    guard = 0;
    @(negedge clk);
    byte_in = b; byte_valid = 1'b1; byte_last = last; key_in = k; offset_in = o;
    while (!byte_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    byte_valid = 1'b0; byte_last = 1'b0;
  endtask

  // After a block's final accept: valid must be up one edge later.
  task automatic expect_done(input string name);
    idle();
    check({name, "_valid"}, 64'(block_valid), 64'd1);
    check({name, "_ready_low"}, 64'(byte_ready), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [N2*8-1:0] model;
    int stall, bad_lanes;

    reset_n = 1'b0;
    byte_in = '0; byte_valid = 1'b0; byte_last = 1'b0; key_in = '0; offset_in = '0;
    block_ready = 1'b1;
    byte_in2 = '0; byte_valid2 = 1'b0; byte_last2 = 1'b0; key_in2 = '0; offset_in2 = '0;
    block_ready2 = 1'b1;

    // Reset state
    #2;
    check("rst_valid", 64'(block_valid), 64'd0);
    check("rst_ready", 64'(byte_ready),  64'd0);
    check("rst_data",  64'(block_data),  64'd0);
    check("rst_len",   64'(block_len),   64'd0);
    check("rst_key",   64'(block_key),   64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(byte_ready), 64'd1);

    // 1: full block back-to-back
    sb_q.push_back('{data: 32'h4433_2211, key: 8'h5A, off: 8'h03, len: 3'd4});
    send(8'h11, 1'b0, 8'h5A, 8'h03);
    send(8'h22, 1'b0, 8'h5A, 8'h03);
    send(8'h33, 1'b0, 8'h5A, 8'h03);
    send(8'h44, 1'b0, 8'h5A, 8'h03);
    expect_done("t1");
    @(negedge clk);
    check("t1_consumed", 64'(block_valid), 64'd0);
    check("t1_ready_again", 64'(byte_ready), 64'd1);

    // 2: short block, then full block; no stale upper lanes
    sb_q.push_back('{data: 32'h0000_BBAA, key: 8'h11, off: 8'h22, len: 3'd2});
    send(8'hAA, 1'b0, 8'h11, 8'h22);
    send(8'hBB, 1'b1, 8'h11, 8'h22);
    expect_done("t2a");
    sb_q.push_back('{data: 32'h0403_0201, key: 8'h33, off: 8'h44, len: 3'd4});
    send(8'h01, 1'b0, 8'h33, 8'h44);
    send(8'h02, 1'b0, 8'h33, 8'h44);
    send(8'h03, 1'b0, 8'h33, 8'h44);
    send(8'h04, 1'b0, 8'h33, 8'h44);
    expect_done("t2b");

    // 3: hold in DONE with byte_valid high
    @(posedge clk); #1 block_ready = 1'b0;
    sb_q.push_back('{data: 32'h0D0C_0B0A, key: 8'h77, off: 8'h88, len: 3'd4});
    send(8'h0A, 1'b0, 8'h77, 8'h88);
    send(8'h0B, 1'b0, 8'h77, 8'h88);
    send(8'h0C, 1'b0, 8'h77, 8'h88);
    send(8'h0D, 1'b0, 8'h77, 8'h88);
    @(negedge clk);
    byte_in = 8'hFF; byte_valid = 1'b1; key_in = 8'hFE; offset_in = 8'hFD;
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_ready", 64'(byte_ready),  64'd0);
      check("t3_hold_valid", 64'(block_valid), 64'd1);
      check("t3_hold_data",  64'(block_data),  64'h0D0C_0B0A);
      check("t3_hold_key",   64'(block_key),   64'h77);
      check("t3_hold_len",   64'(block_len),   64'd4);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    @(posedge clk); #1 block_ready = 1'b1;
    @(negedge clk);   // monitor takes the held block here
    @(negedge clk);
    check("t3_idle_valid", 64'(block_valid), 64'd0);
    check("t3_idle_ready", 64'(byte_ready),  64'd1);
    check("t3_sb_empty",   64'(sb_q.size()), 64'd0);

    // 4: key/offset change every byte, gaps in byte_valid
    sb_q.push_back('{data: 32'hC4C3_C2C1, key: 8'h10, off: 8'h20, len: 3'd4});
    send(8'hC1, 1'b0, 8'h10, 8'h20);
    idle(); idle();
    send(8'hC2, 1'b0, 8'h99, 8'h98);
    idle();
    send(8'hC3, 1'b0, 8'h55, 8'h66);
    send(8'hC4, 1'b0, 8'hEE, 8'hEF);
    expect_done("t4");

    // 5: reset mid-fill discards the partial block
    send(8'hD1, 1'b0, 8'hA1, 8'hB1);
    send(8'hD2, 1'b0, 8'hA1, 8'hB1);
    @(negedge clk);
    byte_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t5_rst_data",  64'(block_data),  64'd0);
    check("t5_rst_valid", 64'(block_valid), 64'd0);
    check("t5_rst_ready", 64'(byte_ready),  64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    sb_q.push_back('{data: 32'hE4E3_E2E1, key: 8'h31, off: 8'h41, len: 3'd4});
    send(8'hE1, 1'b0, 8'h31, 8'h41);
    send(8'hE2, 1'b0, 8'h31, 8'h41);
    send(8'hE3, 1'b0, 8'h31, 8'h41);
    send(8'hE4, 1'b0, 8'h31, 8'h41);
    expect_done("t5");
    @(negedge clk);

    // 6: 512-byte block, value k mod 256, back-to-back
    model = '0;
    stall = 0;
    for (int k = 0; k < N2; k++) begin
      @(negedge clk);
      if (k == N2 - 1) check("t6_valid_early", 64'(block_valid2), 64'd0);
      if (!byte_ready2) stall++;
      byte_in2 = 8'(k); byte_valid2 = 1'b1;
      model[8*k +: 8] = 8'(k);
    end
    @(negedge clk);
    byte_valid2 = 1'b0;
    check("t6_stalls", 64'(stall), 64'd0);
    check("t6_valid",  64'(block_valid2), 64'd1);
    check("t6_len",    64'(block_len2),   64'd512);
    check("t6_key",    64'(block_key2),   64'd0);
    check("t6_offset", 64'(block_offset2), 64'd0);
    bad_lanes = 0;
    for (int k = 0; k < N2; k++) begin
      if (block_data2[8*k +: 8] !== model[8*k +: 8]) bad_lanes++;
    end
    check("t6_bad_lanes", 64'(bad_lanes), 64'd0);
    @(negedge clk);
    check("t6_consumed", 64'(block_valid2), 64'd0);
    check("t6_data_cleared", 64'(block_data2 == '0), 64'd1);

    check("final_sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
